agree_br_predictor: RTL
=======================

// Module: agree_br_predictor
// PURPOSE
//  Agree branch predictor plus branch-resolution logic; sits beside brc.
//  - IF stage: looks up i_if_pc and supplies a taken/target prediction.
//  - EX stage: consumes brc's o_br_less/o_br_equal and funct3 to form the
//    real outcome, flags mispredicts, gives the redirect PC, trains tables.
// PARAMETERS
//  BTB_ENTRIES  64   direct-mapped BTB depth; power of two
//  GHR_W        8    global history length; PHT depth = 2**GHR_W
// PORTS
//  i_clk             in   1      clock, rising edge
//  i_rst             in   1      reset, asynchronous, active-high
//  i_if_pc           in   32     fetch PC
//  o_pred_hit        out  1      BTB hit for i_if_pc
//  o_pred_taken      out  1      predicted taken
//  o_pred_target     out  32     predicted next PC (i_if_pc+4 if not taken)
//  o_if_ghr          out  GHR_W  GHR snapshot; pipelined to EX with the instr
//  i_ex_valid        in   1      EX holds a valid, non-flushed instruction
//  i_ex_is_br        in   1      conditional branch (B-type)
//  i_ex_is_jmp       in   1      JAL/JALR
//  i_ex_funct3       in   3      branch funct3
//  i_br_less         in   1      from brc o_br_less
//  i_br_equal        in   1      from brc o_br_equal
//  i_ex_pc           in   32     PC of EX instruction
//  i_ex_target       in   32     computed branch/jump target
//  i_ex_pred_taken   in   1      prediction carried from IF
//  i_ex_pred_target  in   32     predicted next PC carried from IF
//  i_ex_ghr          in   GHR_W  o_if_ghr carried from IF
//  o_ex_taken        out  1      resolved outcome
//  o_mispredict      out  1      flush IF/ID, redirect fetch
//  o_redirect_pc     out  32     correct next PC when o_mispredict=1
// BEHAVIOUR
//  - State: BTB {valid,tag,target,bias}, PHT of 2-bit ctrs, GHR.
//  - Reset (async): BTB valid=0, PHT ctrs=2'b10 (weak agree), GHR=0.
//    During/after reset: o_pred_hit=0, o_pred_taken=0, o_pred_target=pc+4,
//    o_mispredict=0 unless i_ex_valid.
//  - Lookup (comb., 0 latency): btb_idx=pc[IDX+1:2], tag=pc[31:IDX+2];
//    pht_idx=pc[GHR_W+1:2]^GHR. Hit: agree=ctr[1]; taken=agree?bias:~bias.
//    Miss: not taken.
//  - Outcome (comb.): 000 eq, 001 !eq, 100/110 less, 101/111 !less;
//    010/011 not taken, no training. Jump: always taken.
//  - o_mispredict = i_ex_valid & (is_br|is_jmp) & (taken!=pred_taken |
//    (taken & target!=pred_target)); also set if not br/jmp but
//    pred_taken=1 (stale alias). redirect = taken ? target : ex_pc+4.
//  - Train on clock edge when i_ex_valid, using pht_idx=ex_pc^i_ex_ghr:
//    br hit: ctr +1 if taken==bias else -1, saturating 0..3; refresh target
//      if taken.
//    br miss & taken: allocate {1,tag,target,bias=1}; PHT untouched.
//    br miss & not taken: no allocation. jmp: allocate/overwrite, bias=1.
//    GHR <= {GHR[GHR_W-2:0],taken} on every trained conditional branch.
//  - Same-cycle lookup/update of same entry: lookup sees old contents.
//  - i_ex_valid=0 (stall/flush bubble): no state change, o_mispredict=0.
// STRUCTURE
//  - br_pkg: funct3 constants, CTR_WEAK_AGREE=2'b10, btb_entry_t struct.
//  - Sub-module agree_btb (tag/target/bias array, read+write port);
//    PHT, GHR, resolve logic stay in the top.
// TESTING
//  - Reset, pc=0x100 -> hit=0, taken=0, target=0x104; GHR=0.
//  - BEQ @0x100 equal=1, target 0x80, pred 0 -> mispredict, redirect 0x80;
//    next pc 0x100 -> hit=1, bias=1, taken=1, target=0x80.
//  - Same BEQ equal=0 x3 -> ctr 2->1->0; pred not taken;
//    no mispredict when pred 0.
//  - BGEU less=0 taken, BLT less=0 not taken; funct3=010 -> no train, GHR held.
//  - JALR @0x200 target 0x300 then 0x340, pred 0x300 -> mispredict,
//    redirect 0x340, BTB target becomes 0x340.
//  - Assert i_rst mid-train -> tables clear at once; hit=0 next lookup.

Source files
------------

// File: rtl/br_pkg.sv
// Shared definitions for the agree branch predictor: branch funct3 codes,
// PHT counter constants and the BTB entry layout.
package br_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] CTR_WEAK_AGREE = 2'b10;
   localparam logic [1:0] CTR_MAX        = 2'b11;
   localparam logic [1:0] CTR_MIN        = 2'b00;

   // Tag field is sized for the smallest BTB; unused upper bits stay zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      logic        bias;
   } btb_entry_t;

   function automatic logic [1:0] ctr_step(input logic [1:0] ctr,
                                           input logic       up);
      if (up)
         return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
      else
         return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/agree_btb.sv
// Direct-mapped BTB holding tag, target and agree bias per entry.
// One lookup port for IF, one probe+write port for EX training.
module agree_btb
   import br_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic [31:0] rd_target,
   output logic        rd_bias,
   input  logic [31:0] ex_pc,
   output logic        ex_hit,
   output logic        ex_bias,
   input  logic        wr_en,
   input  logic [31:0] wr_target,
   input  logic        wr_bias
);

   localparam int IDX_W = $clog2(ENTRIES);

   btb_entry_t       mem_q [ENTRIES];
   btb_entry_t       rd_e;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [29:0]      rd_tag;
   logic [29:0]      ex_tag;

   assign rd_idx = rd_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign rd_tag = 30'(rd_pc >> (IDX_W + 2));
   assign ex_tag = 30'(ex_pc >> (IDX_W + 2));

   assign rd_e      = mem_q[rd_idx];
   assign rd_hit    = rd_e.valid && (rd_e.tag == rd_tag);
   assign rd_target = rd_e.target;
   assign rd_bias   = rd_e.bias;

   assign ex_hit  = mem_q[ex_idx].valid && (mem_q[ex_idx].tag == ex_tag);
   assign ex_bias = mem_q[ex_idx].bias;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++)
            mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[ex_idx] <= '{valid:  1'b1,
                            tag:    ex_tag,
                            target: wr_target,
                            bias:   wr_bias};
      end
   end

endmodule

// File: rtl/agree_br_predictor.sv
// Agree branch predictor with EX-stage branch resolution, mispredict
// detection, redirect generation and PHT/BTB/GHR training.
module agree_br_predictor
   import br_pkg::*;
#(
   parameter int BTB_ENTRIES = 64,
   parameter int GHR_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_if_pc,
   output logic             o_pred_hit,
   output logic             o_pred_taken,
   output logic [31:0]      o_pred_target,
   output logic [GHR_W-1:0] o_if_ghr,
   input  logic             i_ex_valid,
   input  logic             i_ex_is_br,
   input  logic             i_ex_is_jmp,
   input  logic [2:0]       i_ex_funct3,
   input  logic             i_br_less,
   input  logic             i_br_equal,
   input  logic [31:0]      i_ex_pc,
   input  logic [31:0]      i_ex_target,
   input  logic             i_ex_pred_taken,
   input  logic [31:0]      i_ex_pred_target,
   input  logic [GHR_W-1:0] i_ex_ghr,
   output logic             o_ex_taken,
   output logic             o_mispredict,
   output logic [31:0]      o_redirect_pc
);

   localparam int PHT_N = 1 << GHR_W;

   logic [1:0]       pht_q [PHT_N];
   logic [GHR_W-1:0] ghr_q;
   logic [GHR_W-1:0] if_pht_idx;
   logic [GHR_W-1:0] ex_pht_idx;
   logic             if_hit;
   logic             if_bias;
   logic [31:0]      if_target;
   logic             ex_hit;
   logic             ex_bias;
   logic             agree;
   logic             cond;
   logic             cond_ok;
   logic             br_train;
   logic             wr_en;
   logic             wr_bias;

   agree_btb #(
      .ENTRIES(BTB_ENTRIES)
   ) u_btb (
      .clk      (i_clk),
      .rst      (i_rst),
      .rd_pc    (i_if_pc),
      .rd_hit   (if_hit),
      .rd_target(if_target),
      .rd_bias  (if_bias),
      .ex_pc    (i_ex_pc),
      .ex_hit   (ex_hit),
      .ex_bias  (ex_bias),
      .wr_en    (wr_en),
      .wr_target(i_ex_target),
      .wr_bias  (wr_bias)
   );

   assign if_pht_idx    = i_if_pc[GHR_W+1:2] ^ ghr_q;
   assign ex_pht_idx    = i_ex_pc[GHR_W+1:2] ^ i_ex_ghr;
   assign agree         = pht_q[if_pht_idx][1];
   assign o_pred_hit    = if_hit;
   assign o_pred_taken  = if_hit & (agree ? if_bias : ~if_bias);
   assign o_pred_target = o_pred_taken ? if_target : i_if_pc + 32'd4;
   assign o_if_ghr      = ghr_q;

   always_comb begin
      cond    = 1'b0;
      cond_ok = 1'b1;
      case (i_ex_funct3)
         F3_BEQ:           cond = i_br_equal;
         F3_BNE:           cond = ~i_br_equal;
         F3_BLT, F3_BLTU:  cond = i_br_less;
         F3_BGE, F3_BGEU:  cond = ~i_br_less;
         default:          cond_ok = 1'b0;
      endcase
   end

   assign o_ex_taken = i_ex_is_jmp | (i_ex_is_br & cond_ok & cond);

   // A non-control instruction predicted taken is a stale BTB alias.
   always_comb begin
      o_mispredict = 1'b0;
      if (i_ex_valid) begin
         if (i_ex_is_br | i_ex_is_jmp)
            o_mispredict = (o_ex_taken != i_ex_pred_taken) |
                           (o_ex_taken & (i_ex_target != i_ex_pred_target));
         else
            o_mispredict = i_ex_pred_taken;
      end
   end

   assign o_redirect_pc = o_ex_taken ? i_ex_target : i_ex_pc + 32'd4;

   assign br_train = i_ex_valid & i_ex_is_br & ~i_ex_is_jmp & cond_ok;
   assign wr_en    = (i_ex_valid & i_ex_is_jmp) | (br_train & o_ex_taken);
   assign wr_bias  = i_ex_is_jmp | ~ex_hit | ex_bias;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < PHT_N; i++)
            pht_q[i] <= CTR_WEAK_AGREE;
         ghr_q <= '0;
      end else if (br_train) begin
         if (ex_hit)
            pht_q[ex_pht_idx] <= ctr_step(pht_q[ex_pht_idx],
                                          o_ex_taken == ex_bias);
         ghr_q <= {ghr_q[GHR_W-2:0], o_ex_taken};
      end
   end

endmodule
